fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter STACK_DEPTH, default 4, number of return-address stack entries (power of two, 2..16).
REQ-002 Parameter RESET_VECTOR, default 16'd0, first fetch address after reset.
REQ-003 Clock  input  1  single clock, all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 oAddress  output  16  fetch address to program ROM (combinational ROM, same-cycle data).
REQ-006 iInstruction  input  28  ROM word at oAddress: [27:24] opcode, [23:16] target/destination, [15:0] operands.
REQ-007 iStall  input  1  execute stage busy; sequencer holds all state while high.
REQ-008 oInstruction  output  28  registered instruction issued to execute stage.
REQ-009 oInstrValid  output  1  oInstruction is a new, non-control-flow instruction this cycle.
REQ-010 oHalted  output  1  sequencer in HALT state.
REQ-011 oStackError  output  2  sticky: [1] overflow, [0] underflow.

Function
REQ-012 States SHALL be RUN and HALT; Reset enters RUN.
REQ-013 oAddress SHALL equal the PC register (no combinational path from iInstruction).
REQ-014 Opcodes SHALL be decoded using the team definitions header values `JMP, `CALL, `RET; all others are pass-through.
REQ-015 In RUN with iStall=0, each edge: pass-through opcode -> oInstruction<=iInstruction, oInstrValid<=1, PC<=PC+1.
REQ-016 `JMP -> PC<={8'h00, iInstruction[23:16]}, oInstrValid<=0, oInstruction holds.
REQ-017 `CALL with stack not full -> push PC+1, PC<={8'h00, iInstruction[23:16]}, oInstrValid<=0.
REQ-018 `RET with stack not empty -> PC<=top entry, pop, oInstrValid<=0; iInstruction[23:0] ignored.
REQ-019 `CALL with STACK_DEPTH entries used -> no push, oStackError[1]<=1, state<=HALT, PC holds.
REQ-020 `RET with stack empty -> oStackError[0]<=1, state<=HALT, PC holds.
REQ-021 Issue latency SHALL be exactly one cycle from oAddress presentation to oInstrValid.
REQ-022 Control-flow instructions SHALL cost exactly one cycle with oInstrValid=0 (one bubble).
REQ-023 iStall=1 SHALL freeze PC, stack, state, oInstruction; oInstrValid<=0 while stalled, so no instruction is issued twice.
REQ-024 PC+1 SHALL wrap 16'hFFFF -> 16'h0000 silently; pushed return address wraps identically.
REQ-025 Stack pointer SHALL be $clog2(STACK_DEPTH)+1 bits so full and empty are distinguishable.
REQ-026 HALT: PC holds, oInstrValid=0, oHalted=1, iInstruction and iStall ignored; exit only via Reset.
REQ-027 oStackError bits SHALL stay set until Reset.

Reset
REQ-028 Reset high SHALL asynchronously force PC=RESET_VECTOR, stack pointer=0, state=RUN, oInstruction=28'd0, oInstrValid=0, oHalted=0, oStackError=2'b00.
REQ-029 Reset SHALL win over any simultaneous stall, call, return or halt condition; stack contents need not be cleared.
REQ-030 Reset asserted mid-program SHALL discard in-flight control flow; first fetch after release at RESET_VECTOR.

Verification
REQ-031 Linear: ROM 0..3 pass-through, release reset -> oAddress 0,1,2,3 on successive cycles; oInstrValid=1 from cycle 1 with words 0,1,2.
REQ-032 Call/return: 3=`CALL target 8, 8=pass-through, 9=`RET -> oAddress 3,8,9,4; stack depth 1 then 0; bubbles after 3 and 9.
REQ-033 Jump loop: 5=`JMP target 5 -> oAddress stays 5, oInstrValid=0 permanently, no error.
REQ-034 Overflow: 0=`CALL target 0, STACK_DEPTH=4 -> four pushes, fifth CALL sets oStackError=2'b10, oHalted=1, oAddress=0.
REQ-035 Underflow plus stall: iStall=1 for 3 cycles at PC=2 (state frozen, oInstrValid=0), then 2=`RET on empty stack -> oStackError=2'b01, oHalted=1.
REQ-036 Reset asserted asynchronously mid-cycle during HALT -> all outputs at reset values before next edge; fetch resumes at RESET_VECTOR.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC, return-address stack and RUN/HALT control
// feeding one registered instruction per cycle to the execute stage.

`ifndef JMP
`define JMP  4'h1
`endif
`ifndef CALL
`define CALL 4'h2
`endif
`ifndef RET
`define RET  4'h3
`endif

module fetch_sequencer #(
    parameter int          STACK_DEPTH  = 4,
    parameter logic [15:0] RESET_VECTOR = 16'd0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [15:0] oAddress,
    input  logic [27:0] iInstruction,
    input  logic        iStall,
    output logic [27:0] oInstruction,
    output logic        oInstrValid,
    output logic        oHalted,
    output logic [1:0]  oStackError
);

    localparam int SP_W  = $clog2(STACK_DEPTH) + 1;
    localparam int IDX_W = SP_W - 1;

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } state_t;

    state_t            r_state, w_state_next;
    logic [15:0]       r_pc, w_pc_next;
    logic [SP_W-1:0]   r_sp, w_sp_next;
    logic [27:0]       r_instr, w_instr_next;
    logic              r_valid, w_valid_next;
    logic [1:0]        r_err, w_err_next;
    logic [15:0]       r_stack [STACK_DEPTH];

    logic              w_push;
    logic [3:0]        w_opcode;
    logic [15:0]       w_pc_inc;
    logic [15:0]       w_target;
    logic [15:0]       w_top;
    logic              w_full;
    logic              w_empty;
    logic [IDX_W-1:0]  w_push_idx;
    logic [IDX_W-1:0]  w_top_idx;

    assign w_opcode   = iInstruction[27:24];
    assign w_target   = {8'h00, iInstruction[23:16]};
    assign w_pc_inc   = r_pc + 16'd1;
    assign w_full     = (r_sp == SP_W'(STACK_DEPTH));
    assign w_empty    = (r_sp == '0);
    assign w_push_idx = r_sp[IDX_W-1:0];
    assign w_top_idx  = IDX_W'(r_sp - SP_W'(1));
    assign w_top      = r_stack[w_top_idx];

    // NOTE: every output of this block gets a default before any branch, so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_sp_next    = r_sp;
        w_instr_next = r_instr;
        w_valid_next = 1'b0;
        w_err_next   = r_err;
        w_push       = 1'b0;

        if (r_state == ST_RUN && !iStall) begin
            case (w_opcode)
                `JMP: begin
                    w_pc_next = w_target;
                end
                `CALL: begin
                    if (w_full) begin
                        w_err_next[1] = 1'b1;
                        w_state_next  = ST_HALT;
                    end else begin
                        w_push    = 1'b1;
                        w_sp_next = r_sp + SP_W'(1);
                        w_pc_next = w_target;
                    end
                end
                `RET: begin
                    if (w_empty) begin
                        w_err_next[0] = 1'b1;
                        w_state_next  = ST_HALT;
                    end else begin
                        w_sp_next = r_sp - SP_W'(1);
                        w_pc_next = w_top;
                    end
                end
                default: begin
                    w_instr_next = iInstruction;
                    w_valid_next = 1'b1;
                    w_pc_next    = w_pc_inc;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_VECTOR;
            r_sp    <= '0;
            r_instr <= 28'd0;
            r_valid <= 1'b0;
            r_err   <= 2'b00;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_sp    <= w_sp_next;
            r_instr <= w_instr_next;
            r_valid <= w_valid_next;
            r_err   <= w_err_next;
        end
    end

    // NOTE: the stack array has no reset; the pointer alone defines which entries are live.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end

    assign oAddress     = r_pc;
    assign oInstruction = r_instr;
    assign oInstrValid  = r_valid;
    assign oHalted      = (r_state == ST_HALT);
    assign oStackError  = r_err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer: a behavioural ROM feeds the DUT and
// each scenario task compares outputs against hand-derived values.

`ifndef JMP
`define JMP  4'h1
`endif
`ifndef CALL
`define CALL 4'h2
`endif
`ifndef RET
`define RET  4'h3
`endif

module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;

    logic [15:0] addr;
    logic [27:0] rom_word;
    logic [27:0] instr;
    logic        valid;
    logic        halted;
    logic [1:0]  err;

    logic [15:0] w_addr;
    logic [27:0] w_rom_word;
    logic [27:0] w_instr;
    logic        w_valid;
    logic        w_halted;
    logic [1:0]  w_err;
    logic [27:0] rom2_ffff = 28'h5000000;

    logic [27:0] rom [256];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign rom_word   = rom[addr[7:0]];
    assign w_rom_word = (w_addr == 16'hFFFF) ? rom2_ffff :
                        (w_addr == 16'h0010) ? {`RET, 24'h000000} :
                                               {4'h5, 8'h00, w_addr};

    fetch_sequencer dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .oAddress     (addr),
        .iInstruction (rom_word),
        .iStall       (stall),
        .oInstruction (instr),
        .oInstrValid  (valid),
        .oHalted      (halted),
        .oStackError  (err)
    );

    fetch_sequencer #(.STACK_DEPTH(2), .RESET_VECTOR(16'hFFFF)) dut_w (
        .i_clk        (clk),
        .i_rst        (rst),
        .oAddress     (w_addr),
        .iInstruction (w_rom_word),
        .iStall       (stall),
        .oInstruction (w_instr),
        .oInstrValid  (w_valid),
        .oHalted      (w_halted),
        .oStackError  (w_err)
    );

    function automatic logic [27:0] pw(input int i);
        return {4'h5, 8'h00, 16'(16'hA000 + i)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = pw(i);
    endtask

    task automatic pulse_reset();
        rst   = 1'b1;
        stall = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear_rom();
        stall = 1'b1;
        rst   = 1'b1;
        tick();
        checks++; if (addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got=%h exp=0000", addr); end
        checks++; if (instr !== 28'd0) begin errors++; $display("FAIL reset_instr got=%h exp=0", instr); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err got=%b exp=00", err); end
        stall = 1'b0;
    endtask

    task automatic test_linear();
        clear_rom();
        pulse_reset();
        checks++; if (addr !== 16'd0) begin errors++; $display("FAIL linear_c0_addr got=%h exp=0000", addr); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL linear_c0_valid got=%b exp=0", valid); end
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++; if (addr !== 16'(c)) begin errors++; $display("FAIL linear_addr c=%0d got=%h exp=%h", c, addr, 16'(c)); end
            checks++; if (valid !== 1'b1) begin errors++; $display("FAIL linear_valid c=%0d got=%b exp=1", c, valid); end
            checks++; if (instr !== pw(c - 1)) begin errors++; $display("FAIL linear_instr c=%0d got=%h exp=%h", c, instr, pw(c - 1)); end
        end
    endtask

    task automatic test_call_ret();
        logic [15:0] ea [7] = '{16'd1, 16'd2, 16'd3, 16'd8, 16'd9, 16'd4, 16'd5};
        logic        ev [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [27:0] ei [7] = '{pw(0), pw(1), pw(2), pw(2), pw(8), pw(8), pw(4)};
        int          es [7] = '{0, 0, 0, 1, 1, 0, 0};
        clear_rom();
        rom[3] = {`CALL, 8'h08, 16'h1234};
        rom[9] = {`RET, 8'h77, 16'h5678};
        pulse_reset();
        for (int e = 0; e < 7; e++) begin
            tick();
            checks++; if (addr !== ea[e]) begin errors++; $display("FAIL callret_addr e=%0d got=%h exp=%h", e + 1, addr, ea[e]); end
            checks++; if (valid !== ev[e]) begin errors++; $display("FAIL callret_valid e=%0d got=%b exp=%b", e + 1, valid, ev[e]); end
            checks++; if (instr !== ei[e]) begin errors++; $display("FAIL callret_instr e=%0d got=%h exp=%h", e + 1, instr, ei[e]); end
            checks++; if (int'(dut.r_sp) !== es[e]) begin errors++; $display("FAIL callret_depth e=%0d got=%0d exp=%0d", e + 1, dut.r_sp, es[e]); end
        end
        checks++; if (err !== 2'b00 || halted !== 1'b0) begin errors++; $display("FAIL callret_noerr got err=%b halted=%b exp err=00 halted=0", err, halted); end
    endtask

    task automatic test_jump_loop();
        clear_rom();
        rom[5] = {`JMP, 8'h05, 16'hFFFF};
        pulse_reset();
        repeat (5) tick();
        checks++; if (addr !== 16'd5) begin errors++; $display("FAIL jmp_reach_addr got=%h exp=0005", addr); end
        checks++; if (valid !== 1'b1 || instr !== pw(4)) begin errors++; $display("FAIL jmp_reach_issue got valid=%b instr=%h exp valid=1 instr=%h", valid, instr, pw(4)); end
        for (int e = 0; e < 4; e++) begin
            tick();
            checks++; if (addr !== 16'd5) begin errors++; $display("FAIL jmp_loop_addr e=%0d got=%h exp=0005", e, addr); end
            checks++; if (valid !== 1'b0) begin errors++; $display("FAIL jmp_loop_valid e=%0d got=%b exp=0", e, valid); end
            checks++; if (err !== 2'b00 || halted !== 1'b0) begin errors++; $display("FAIL jmp_loop_state e=%0d got err=%b halted=%b exp err=00 halted=0", e, err, halted); end
            checks++; if (instr !== pw(4)) begin errors++; $display("FAIL jmp_loop_instr e=%0d got=%h exp=%h", e, instr, pw(4)); end
        end
    endtask

    task automatic test_overflow();
        clear_rom();
        rom[0] = {`CALL, 8'h00, 16'h0000};
        pulse_reset();
        for (int e = 1; e <= 4; e++) begin
            tick();
            checks++; if (addr !== 16'd0 || valid !== 1'b0) begin errors++; $display("FAIL ovf_push_out e=%0d got addr=%h valid=%b exp addr=0000 valid=0", e, addr, valid); end
            checks++; if (err !== 2'b00 || halted !== 1'b0) begin errors++; $display("FAIL ovf_push_state e=%0d got err=%b halted=%b exp err=00 halted=0", e, err, halted); end
            checks++; if (int'(dut.r_sp) !== e) begin errors++; $display("FAIL ovf_depth e=%0d got=%0d exp=%0d", e, dut.r_sp, e); end
        end
        tick();
        checks++; if (err !== 2'b10) begin errors++; $display("FAIL ovf_err got=%b exp=10", err); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL ovf_halted got=%b exp=1", halted); end
        checks++; if (addr !== 16'd0 || valid !== 1'b0) begin errors++; $display("FAIL ovf_hold got addr=%h valid=%b exp addr=0000 valid=0", addr, valid); end
        checks++; if (int'(dut.r_sp) !== 4) begin errors++; $display("FAIL ovf_nopush got=%0d exp=4", dut.r_sp); end
        stall = 1'b1;
        repeat (2) tick();
        stall = 1'b0;
        checks++; if (err !== 2'b10 || halted !== 1'b1 || addr !== 16'd0) begin errors++; $display("FAIL ovf_sticky got err=%b halted=%b addr=%h exp err=10 halted=1 addr=0000", err, halted, addr); end
    endtask

    task automatic test_underflow_stall();
        clear_rom();
        rom[2] = {`RET, 8'h44, 16'h4444};
        pulse_reset();
        repeat (2) tick();
        checks++; if (addr !== 16'd2 || valid !== 1'b1 || instr !== pw(1)) begin errors++; $display("FAIL unf_pre got addr=%h valid=%b instr=%h exp addr=0002 valid=1 instr=%h", addr, valid, instr, pw(1)); end
        stall = 1'b1;
        for (int e = 0; e < 3; e++) begin
            tick();
            checks++; if (addr !== 16'd2) begin errors++; $display("FAIL stall_addr e=%0d got=%h exp=0002", e, addr); end
            checks++; if (valid !== 1'b0) begin errors++; $display("FAIL stall_valid e=%0d got=%b exp=0", e, valid); end
            checks++; if (instr !== pw(1)) begin errors++; $display("FAIL stall_instr e=%0d got=%h exp=%h", e, instr, pw(1)); end
            checks++; if (halted !== 1'b0 || err !== 2'b00) begin errors++; $display("FAIL stall_state e=%0d got halted=%b err=%b exp halted=0 err=00", e, halted, err); end
        end
        stall = 1'b0;
        tick();
        checks++; if (err !== 2'b01) begin errors++; $display("FAIL unf_err got=%b exp=01", err); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL unf_halted got=%b exp=1", halted); end
        checks++; if (addr !== 16'd2 || valid !== 1'b0) begin errors++; $display("FAIL unf_hold got addr=%h valid=%b exp addr=0002 valid=0", addr, valid); end
        tick();
        checks++; if (err !== 2'b01 || halted !== 1'b1) begin errors++; $display("FAIL unf_sticky got err=%b halted=%b exp err=01 halted=1", err, halted); end
    endtask

    task automatic test_async_reset();
        #3;
        rst = 1'b1;
        #1;
        checks++; if (addr !== 16'd0) begin errors++; $display("FAIL async_addr got=%h exp=0000", addr); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL async_halted got=%b exp=0", halted); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL async_err got=%b exp=00", err); end
        checks++; if (valid !== 1'b0 || instr !== 28'd0) begin errors++; $display("FAIL async_issue got valid=%b instr=%h exp valid=0 instr=0", valid, instr); end
        #2;
        rst = 1'b0;
        tick();
        checks++; if (addr !== 16'd1 || valid !== 1'b1 || instr !== pw(0)) begin errors++; $display("FAIL async_resume got addr=%h valid=%b instr=%h exp addr=0001 valid=1 instr=%h", addr, valid, instr, pw(0)); end
    endtask

    task automatic test_wrap();
        rom2_ffff = {4'h5, 8'h00, 16'hBEEF};
        pulse_reset();
        checks++; if (w_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_vector got=%h exp=ffff", w_addr); end
        tick();
        checks++; if (w_addr !== 16'h0000) begin errors++; $display("FAIL wrap_pc got=%h exp=0000", w_addr); end
        checks++; if (w_valid !== 1'b1 || w_instr !== {4'h5, 8'h00, 16'hBEEF}) begin errors++; $display("FAIL wrap_issue got valid=%b instr=%h exp valid=1 instr=500beef", w_valid, w_instr); end
        rom2_ffff = {`CALL, 8'h10, 16'h0000};
        pulse_reset();
        tick();
        checks++; if (w_addr !== 16'h0010 || w_valid !== 1'b0) begin errors++; $display("FAIL wrap_call got addr=%h valid=%b exp addr=0010 valid=0", w_addr, w_valid); end
        tick();
        checks++; if (w_addr !== 16'h0000 || w_valid !== 1'b0) begin errors++; $display("FAIL wrap_ret got addr=%h valid=%b exp addr=0000 valid=0", w_addr, w_valid); end
        tick();
        checks++; if (w_addr !== 16'h0001 || w_valid !== 1'b1 || w_instr !== 28'h5000000) begin errors++; $display("FAIL wrap_resume got addr=%h valid=%b instr=%h exp addr=0001 valid=1 instr=5000000", w_addr, w_valid, w_instr); end
        checks++; if (w_err !== 2'b00 || w_halted !== 1'b0) begin errors++; $display("FAIL wrap_noerr got err=%b halted=%b exp err=00 halted=0", w_err, w_halted); end
    endtask

    initial begin
        test_reset();
        test_linear();
        test_call_ret();
        test_jump_loop();
        test_overflow();
        test_underflow_stall();
        test_async_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1);
    end

endmodule
